mini_core_store_buf: RTL and testbench

MINI_CORE_STORE_BUF -- requirements
Module: mini_core_store_buf

---
 rtl/mini_core_pkg.sv | 23 ++
 rtl/mini_core_st_align.sv | 47 ++++
 rtl/mini_core_store_buf.sv | 115 +++++++++++
 tb/tb_mini_core_store_buf.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mini_core_pkg.sv
// Shared types for the mini core store path: store size encoding and the
// store buffer entry payload.
package mini_core_pkg;

  localparam int unsigned SB_DEPTH_DEF = 4;
  localparam int unsigned XLEN         = 32;
  localparam int unsigned WADDR_W      = XLEN - 2;
  localparam int unsigned BE_W         = XLEN / 8;

  typedef enum logic [1:0] {
    ST_B    = 2'b00,
    ST_H    = 2'b01,
    ST_W    = 2'b10,
    ST_RSVD = 2'b11
  } t_st_size;

  typedef struct packed {
    logic [WADDR_W-1:0] addr;
    logic [XLEN-1:0]    data;
    logic [BE_W-1:0]    be;
  } t_sb_entry;

endpackage

// File: rtl/mini_core_st_align.sv
// Places right-justified store data on its byte lanes, builds the byte
// enables and flags misaligned or illegal-size requests. Purely combinational.
module mini_core_st_align
  import mini_core_pkg::*;
(
  input  logic                req,
  input  t_st_size            size,
  input  logic [1:0]          addr_lo,
  input  logic [XLEN-1:0]     data,
  output logic [XLEN-1:0]     data_c,
  output logic [BE_W-1:0]     be_c,
  output logic                misalign_c
);

  logic bad;

  always_comb begin
    data_c = '0;
    be_c   = '0;
    bad    = 1'b0;
    case (size)
      ST_B: begin
        data_c = XLEN'(data[7:0]) << {addr_lo, 3'b000};
        be_c   = BE_W'(4'b0001) << addr_lo;
      end
      ST_H: begin
        if (addr_lo[1]) begin
          data_c = {data[15:0], 16'h0000};
          be_c   = 4'b1100;
        end else begin
          data_c = {16'h0000, data[15:0]};
          be_c   = 4'b0011;
        end
        bad = addr_lo[0];
      end
      ST_W: begin
        data_c = data;
        be_c   = 4'b1111;
        bad    = (addr_lo != 2'b00);
      end
      default: bad = 1'b1;
    endcase
  end

  assign misalign_c = req && bad;

endmodule

// File: rtl/mini_core_store_buf.sv
// Store buffer: FIFO of aligned stores drained to data memory in order, with
// a word-granular load hazard check against all pending entries.
module mini_core_store_buf
  import mini_core_pkg::*;
#(
  parameter int unsigned SB_DEPTH = SB_DEPTH_DEF
) (
  input  logic                          Clock,
  input  logic                          Rst,
  input  logic                          StReqQ103H,
  input  logic [31:0]                   StAddrQ103H,
  input  logic [31:0]                   StDataQ103H,
  input  t_st_size                      StSizeQ103H,
  output logic                          StReadyQ103H,
  output logic                          MisalignQ103H,
  input  logic                          LdReqQ103H,
  input  logic [31:0]                   LdAddrQ103H,
  output logic                          LdHazardQ103H,
  output logic                          DMemWrReq,
  output logic [31:0]                   DMemWrAddr,
  output logic [31:0]                   DMemWrData,
  output logic [3:0]                    DMemByteEn,
  input  logic                          DMemWrAck,
  output logic                          SbEmpty,
  output logic [$clog2(SB_DEPTH+1)-1:0] SbCount
);

  localparam int unsigned PTR_W = $clog2(SB_DEPTH);
  localparam int unsigned CNT_W = $clog2(SB_DEPTH + 1);

  t_sb_entry           entry_q [SB_DEPTH];
  logic [SB_DEPTH-1:0] valid_q;
  logic [PTR_W-1:0]    head_q;
  logic [PTR_W-1:0]    tail_q;
  logic [CNT_W-1:0]    count_q;

  logic [XLEN-1:0]     st_data_c;
  logic [BE_W-1:0]     st_be_c;
  logic                misalign_c;
  logic                full_c;
  logic                empty_c;
  logic                enq_c;
  logic                deq_c;
  logic                hit_c;
  logic                unused_ld_lo;

  mini_core_st_align u_align (
    .req        (StReqQ103H),
    .size       (StSizeQ103H),
    .addr_lo    (StAddrQ103H[1:0]),
    .data       (StDataQ103H),
    .data_c     (st_data_c),
    .be_c       (st_be_c),
    .misalign_c (misalign_c)
  );

  assign full_c  = (count_q == CNT_W'(SB_DEPTH));
  assign empty_c = (count_q == '0);
  assign enq_c   = StReqQ103H && !full_c && !misalign_c;
  assign deq_c   = !empty_c && DMemWrAck;

  // Control state: valids, pointers and occupancy.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq_c) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      if (deq_c) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      if (enq_c && !deq_c) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!enq_c && deq_c) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Payload storage is qualified by valid_q, so it carries no reset.
  always_ff @(posedge Clock) begin
    if (enq_c) begin
      entry_q[tail_q] <= '{addr: StAddrQ103H[31:2], data: st_data_c, be: st_be_c};
    end
  end

  // The head still counts while it is being acked this cycle.
  always_comb begin
    hit_c = 1'b0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      if (valid_q[PTR_W'(i)] && (entry_q[PTR_W'(i)].addr == LdAddrQ103H[31:2])) begin
        hit_c = 1'b1;
      end
    end
  end

  assign unused_ld_lo  = ^LdAddrQ103H[1:0];

  assign LdHazardQ103H = LdReqQ103H && hit_c;
  assign MisalignQ103H = misalign_c;
  assign StReadyQ103H  = !full_c;
  assign SbEmpty       = empty_c;
  assign SbCount       = count_q;
  assign DMemWrReq     = !empty_c;
  assign DMemWrAddr    = {entry_q[head_q].addr, 2'b00};
  assign DMemWrData    = entry_q[head_q].data;
  assign DMemByteEn    = entry_q[head_q].be;

endmodule

// File: tb/tb_mini_core_store_buf.sv
// Directed bench for mini_core_store_buf: alignment, misalignment, full
// back-pressure, FIFO drain order, load hazard and mid-flight reset.
module tb_mini_core_store_buf;
  import mini_core_pkg::*;

  logic        Clock = 1'b0;
  logic        Rst = 1'b1;
  logic        StReqQ103H = 1'b0;
  logic [31:0] StAddrQ103H = '0;
  logic [31:0] StDataQ103H = '0;
  t_st_size    StSizeQ103H = ST_W;
  logic        StReadyQ103H;
  logic        MisalignQ103H;
  logic        LdReqQ103H = 1'b0;
  logic [31:0] LdAddrQ103H = '0;
  logic        LdHazardQ103H;
  logic        DMemWrReq;
  logic [31:0] DMemWrAddr;
  logic [31:0] DMemWrData;
  logic [3:0]  DMemByteEn;
  logic        DMemWrAck = 1'b0;
  logic        SbEmpty;
  logic [2:0]  SbCount;

  int checks = 0;
  int errors = 0;

  mini_core_store_buf #(.SB_DEPTH(4)) dut (
    .Clock         (Clock),
    .Rst           (Rst),
    .StReqQ103H    (StReqQ103H),
    .StAddrQ103H   (StAddrQ103H),
    .StDataQ103H   (StDataQ103H),
    .StSizeQ103H   (StSizeQ103H),
    .StReadyQ103H  (StReadyQ103H),
    .MisalignQ103H (MisalignQ103H),
    .LdReqQ103H    (LdReqQ103H),
    .LdAddrQ103H   (LdAddrQ103H),
    .LdHazardQ103H (LdHazardQ103H),
    .DMemWrReq     (DMemWrReq),
    .DMemWrAddr    (DMemWrAddr),
    .DMemWrData    (DMemWrData),
    .DMemByteEn    (DMemByteEn),
    .DMemWrAck     (DMemWrAck),
    .SbEmpty       (SbEmpty),
    .SbCount       (SbCount)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 2 time units after the edge.
  task automatic cyc();
    @(posedge Clock);
    #2;
  endtask

  task automatic st(input logic req, input logic [31:0] a, input logic [31:0] d, input t_st_size s);
    StReqQ103H  = req;
    StAddrQ103H = a;
    StDataQ103H = d;
    StSizeQ103H = s;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    chk({tag, "_req"},  32'(DMemWrReq), 32'd1);
    chk({tag, "_addr"}, DMemWrAddr, a);
    chk({tag, "_data"}, DMemWrData, d);
    chk({tag, "_be"},   32'(DMemByteEn), 32'(be));
  endtask

  initial begin
    // Reset state
    cyc();
    cyc();
    Rst = 1'b0;
    #1;
    chk("rst_empty", 32'(SbEmpty), 32'd1);
    chk("rst_wrreq", 32'(DMemWrReq), 32'd0);
    chk("rst_ready", 32'(StReadyQ103H), 32'd1);
    chk("rst_count", 32'(SbCount), 32'd0);

    // SB to 0x1003 with Ack held high
    DMemWrAck = 1'b1;
    st(1'b1, 32'h0000_1003, 32'h0000_00AB, ST_B);
    #1;
    chk("sb_misalign", 32'(MisalignQ103H), 32'd0);
    chk("sb_no_bypass", 32'(DMemWrReq), 32'd0);
    cyc();
    st(1'b0, 32'h0, 32'h0, ST_W);
    #1;
    chk_head("sb", 32'h0000_1000, 32'hAB00_0000, 4'b1000);
    chk("sb_count", 32'(SbCount), 32'd1);
    cyc();
    DMemWrAck = 1'b0;
    #1;
    chk("sb_empty_after_ack", 32'(SbEmpty), 32'd1);
    chk("sb_wrreq_after_ack", 32'(DMemWrReq), 32'd0);

    // Misaligned SH to 0x2001 is rejected
    st(1'b1, 32'h0000_2001, 32'h0000_1234, ST_H);
    #1;
    chk("sh_mis", 32'(MisalignQ103H), 32'd1);
    cyc();
    st(1'b0, 32'h0, 32'h0, ST_W);
    #1;
    chk("sh_mis_count", 32'(SbCount), 32'd0);
    chk("sh_mis_wrreq", 32'(DMemWrReq), 32'd0);

    // Misalign decode only, request withdrawn before the edge
    st(1'b1, 32'h0000_1002, 32'h0, ST_W);
    #1;
    chk("sw_mis", 32'(MisalignQ103H), 32'd1);
    st(1'b1, 32'h0000_1000, 32'h0, ST_RSVD);
    #1;
    chk("rsvd_mis", 32'(MisalignQ103H), 32'd1);
    StReqQ103H = 1'b0;
    #1;
    chk("rsvd_noreq", 32'(MisalignQ103H), 32'd0);

    // Aligned SH upper half, then SB lane 1
    st(1'b1, 32'h0000_2002, 32'hFFFF_1234, ST_H);
    #1;
    chk("sh_ok_mis", 32'(MisalignQ103H), 32'd0);
    cyc();
    st(1'b0, 32'h0, 32'h0, ST_W);
    #1;
    chk_head("sh", 32'h0000_2000, 32'h1234_0000, 4'b1100);
    DMemWrAck = 1'b1;
    cyc();
    DMemWrAck = 1'b0;
    st(1'b1, 32'h0000_1001, 32'h1234_5655, ST_B);
    cyc();
    st(1'b0, 32'h0, 32'h0, ST_W);
    #1;
    chk_head("sb1", 32'h0000_1000, 32'h0000_5500, 4'b0010);
    DMemWrAck = 1'b1;
    cyc();
    DMemWrAck = 1'b0;
    #1;
    chk("sb1_empty", 32'(SbEmpty), 32'd1);

    // Fill with Ack low: fifth store is refused
    for (int k = 0; k < 5; k++) begin
      st(1'b1, 32'h0000_4000 + 32'(4 * k), 32'h1111_1111 * 32'(k + 1), ST_W);
      #1;
      chk($sformatf("fill_ready%0d", k), 32'(StReadyQ103H), (k < 4) ? 32'd1 : 32'd0);
      cyc();
    end
    st(1'b0, 32'h0, 32'h0, ST_W);
    #1;
    chk("full_count", 32'(SbCount), 32'd4);
    chk("full_ready", 32'(StReadyQ103H), 32'd0);

    // Full and acked in the same cycle: still no bypass
    DMemWrAck = 1'b1;
    st(1'b1, 32'h0000_5000, 32'h0000_0005, ST_W);
    #1;
    chk("full_ack_ready", 32'(StReadyQ103H), 32'd0);
    chk_head("drain0", 32'h0000_4000, 32'h1111_1111, 4'b1111);
    cyc();
    st(1'b0, 32'h0, 32'h0, ST_W);
    for (int k = 1; k < 4; k++) begin
      #1;
      chk_head($sformatf("drain%0d", k), 32'h0000_4000 + 32'(4 * k), 32'h1111_1111 * 32'(k + 1), 4'b1111);
      chk($sformatf("drain_count%0d", k), 32'(SbCount), 32'(4 - k));
      cyc();
    end
    DMemWrAck = 1'b0;
    #1;
    chk("drain_empty", 32'(SbEmpty), 32'd1);
    chk("drain_wrreq", 32'(DMemWrReq), 32'd0);

    // Simultaneous enqueue and dequeue keeps the count
    st(1'b1, 32'h0000_6000, 32'h0000_0060, ST_W);
    cyc();
    st(1'b1, 32'h0000_6004, 32'h0000_0064, ST_W);
    DMemWrAck = 1'b1;
    #1;
    chk("simul_pre_count", 32'(SbCount), 32'd1);
    chk("simul_pre_addr", DMemWrAddr, 32'h0000_6000);
    cyc();
    st(1'b0, 32'h0, 32'h0, ST_W);
    #1;
    chk("simul_count", 32'(SbCount), 32'd1);
    chk_head("simul", 32'h0000_6004, 32'h0000_0064, 4'b1111);
    cyc();
    DMemWrAck = 1'b0;
    #1;
    chk("simul_empty", 32'(SbEmpty), 32'd1);

    // Load hazard against a pending word
    st(1'b1, 32'h0000_3000, 32'hDEAD_BEEF, ST_W);
    cyc();
    st(1'b0, 32'h0, 32'h0, ST_W);
    LdReqQ103H  = 1'b1;
    LdAddrQ103H = 32'h0000_3002;
    #1;
    chk("haz_same_word", 32'(LdHazardQ103H), 32'd1);
    LdAddrQ103H = 32'h0000_3004;
    #1;
    chk("haz_next_word", 32'(LdHazardQ103H), 32'd0);
    LdReqQ103H  = 1'b0;
    LdAddrQ103H = 32'h0000_3000;
    #1;
    chk("haz_noreq", 32'(LdHazardQ103H), 32'd0);
    LdReqQ103H = 1'b1;
    DMemWrAck  = 1'b1;
    #1;
    chk("haz_during_ack", 32'(LdHazardQ103H), 32'd1);
    cyc();
    DMemWrAck = 1'b0;
    #1;
    chk("haz_after_ack", 32'(LdHazardQ103H), 32'd0);
    LdReqQ103H = 1'b0;

    // Reset with two stores pending, Ack low
    st(1'b1, 32'h0000_7000, 32'h0000_0070, ST_W);
    cyc();
    st(1'b1, 32'h0000_7004, 32'h0000_0074, ST_W);
    cyc();
    st(1'b0, 32'h0, 32'h0, ST_W);
    #1;
    chk("pre_rst_count", 32'(SbCount), 32'd2);
    Rst = 1'b1;
    cyc();
    Rst = 1'b0;
    #1;
    chk("mid_rst_wrreq", 32'(DMemWrReq), 32'd0);
    chk("mid_rst_count", 32'(SbCount), 32'd0);
    chk("mid_rst_empty", 32'(SbEmpty), 32'd1);
    chk("mid_rst_ready", 32'(StReadyQ103H), 32'd1);
    LdReqQ103H  = 1'b1;
    LdAddrQ103H = 32'h0000_7000;
    #1;
    chk("mid_rst_haz", 32'(LdHazardQ103H), 32'd0);
    LdReqQ103H = 1'b0;

    // Reset wins over a concurrent ack
    st(1'b1, 32'h0000_8000, 32'h0000_0080, ST_W);
    cyc();
    st(1'b0, 32'h0, 32'h0, ST_W);
    Rst       = 1'b1;
    DMemWrAck = 1'b1;
    cyc();
    Rst       = 1'b0;
    DMemWrAck = 1'b0;
    #1;
    chk("rst_ack_wrreq", 32'(DMemWrReq), 32'd0);
    chk("rst_ack_count", 32'(SbCount), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
